// File: rtl/mat_mul_tile_ctrl_pkg.sv
// mat_mul_pkg: shared types and width helpers for the tiled mat_mul sequencer.
//   mm_ctrl_state_t : controller state encoding
//   MM_LAT_OF(n)    : datapath latency of an n x n tile multiplier
//   AW_OF / TW_OF   : tile-buffer address width / tile-count width for MAX_T
package mat_mul_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_OUTPUT = 3'd4,
    ST_FIN    = 3'd5
  } mm_ctrl_state_t;

  // Adder-tree depth plus one register stage.
  function automatic int MM_LAT_OF(input int n);
    return $clog2(n) + 1;
  endfunction

  function automatic int AW_OF(input int max_t);
    return $clog2(max_t * max_t);
  endfunction

  function automatic int TW_OF(input int max_t);
    return $clog2(max_t) + 1;
  endfunction

endpackage

// File: rtl/mat_mul_tile_ctrl_if.sv
// mat_mul_tile_ctrl_if: command, tile-buffer, datapath and result handshake
// signals of the tile controller.
//   master : the controller (drives busy/done/rd_en/addresses/mm_*/out_*/err)
//   slave  : host, buffers, datapath and result consumer
interface mat_mul_tile_ctrl_if #(
  parameter int AW = 6,
  parameter int TW = 4
);
  logic          start;
  logic [TW-1:0] cfg_tiles;
  logic          busy;
  logic          done;
  logic          rd_en;
  logic [AW-1:0] a_addr;
  logic [AW-1:0] b_addr;
  logic          mm_clr;
  logic          mm_valid_in;
  logic          mm_valid_out;
  logic          out_valid;
  logic          out_ready;
  logic [TW-2:0] out_row;
  logic [TW-2:0] out_col;
  logic          err;

  modport master (
    input  start, cfg_tiles, mm_valid_out, out_ready,
    output busy, done, rd_en, a_addr, b_addr, mm_clr, mm_valid_in,
           out_valid, out_row, out_col, err
  );

  modport slave (
    output start, cfg_tiles, mm_valid_out, out_ready,
    input  busy, done, rd_en, a_addr, b_addr, mm_clr, mm_valid_in,
           out_valid, out_row, out_col, err
  );
endinterface

// File: rtl/mm_tile_addr_gen.sv
// mm_tile_addr_gen: i/j/k tile counters and incremental tile-buffer addresses.
//   a_addr = i*T + k is built from a row base that steps by T per row;
//   b_addr = k*T + j starts at j and steps by T per k. No multiplier.
// Ports:
//   clk, resetn : clock, synchronous active-high reset
//   tiles_i     : latched tiles-per-side T
//   init_i      : new command, zero all counters
//   load_i      : start of a tile, k=0 and load first addresses
//   step_i      : one operand pair issued, advance k (holds at k=T-1)
//   adv_i       : output tile accepted, advance j then i (row-major)
//   a_addr_o/b_addr_o : registered buffer addresses
//   row_o/col_o : current output tile (i, j)
//   last_k_o    : k == T-1;  last_tile_o : (i, j) == (T-1, T-1)
module mm_tile_addr_gen
  import mat_mul_pkg::*;
#(
  parameter int AW = 6,
  parameter int TW = 4
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [TW-1:0] tiles_i,
  input  logic          init_i,
  input  logic          load_i,
  input  logic          step_i,
  input  logic          adv_i,
  output logic [AW-1:0] a_addr_o,
  output logic [AW-1:0] b_addr_o,
  output logic [TW-2:0] row_o,
  output logic [TW-2:0] col_o,
  output logic          last_k_o,
  output logic          last_tile_o
);

  logic [TW-2:0] i_q, i_d;
  logic [TW-2:0] j_q, j_d;
  logic [TW-1:0] k_q, k_d;
  logic [AW-1:0] a_base_q, a_base_d;
  logic [AW-1:0] a_addr_q, a_addr_d;
  logic [AW-1:0] b_addr_q, b_addr_d;

  logic [TW-1:0] t_m1_s;
  logic [AW-1:0] t_ext_s;
  logic          last_col_s;
  logic          last_row_s;

  assign t_m1_s     = tiles_i - {{(TW-1){1'b0}}, 1'b1};
  assign t_ext_s    = AW'(tiles_i);
  assign last_k_o   = (k_q == t_m1_s);
  assign last_col_s = ({1'b0, j_q} == t_m1_s);
  assign last_row_s = ({1'b0, i_q} == t_m1_s);

  // Next-state of counters and address pointers.
  always_comb begin
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    a_base_d = a_base_q;
    a_addr_d = a_addr_q;
    b_addr_d = b_addr_q;
    if (init_i) begin
      i_d      = {(TW-1){1'b0}};
      j_d      = {(TW-1){1'b0}};
      k_d      = {TW{1'b0}};
      a_base_d = {AW{1'b0}};
      a_addr_d = {AW{1'b0}};
      b_addr_d = {AW{1'b0}};
    end else if (load_i) begin
      k_d      = {TW{1'b0}};
      a_addr_d = a_base_q;
      b_addr_d = AW'(j_q);
    end else if (step_i) begin
      if (!last_k_o) begin
        k_d      = k_q + {{(TW-1){1'b0}}, 1'b1};
        a_addr_d = a_addr_q + {{(AW-1){1'b0}}, 1'b1};
        b_addr_d = b_addr_q + t_ext_s;
      end else begin
        k_d = k_q;
      end
    end else if (adv_i) begin
      if (!last_col_s) begin
        j_d = j_q + {{(TW-2){1'b0}}, 1'b1};
      end else if (!last_row_s) begin
        j_d      = {(TW-1){1'b0}};
        i_d      = i_q + {{(TW-2){1'b0}}, 1'b1};
        a_base_d = a_base_q + t_ext_s;
      end else begin
        // Final tile: controller leaves for FIN, counters are re-zeroed on the next start.
        j_d = j_q;
      end
    end else begin
      k_d = k_q;
    end
  end

  // Counter and address registers.
  always_ff @(posedge clk) begin
    if (resetn) begin
      i_q      <= {(TW-1){1'b0}};
      j_q      <= {(TW-1){1'b0}};
      k_q      <= {TW{1'b0}};
      a_base_q <= {AW{1'b0}};
      a_addr_q <= {AW{1'b0}};
      b_addr_q <= {AW{1'b0}};
    end else begin
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      a_base_q <= a_base_d;
      a_addr_q <= a_addr_d;
      b_addr_q <= b_addr_d;
    end
  end

  assign a_addr_o    = a_addr_q;
  assign b_addr_o    = b_addr_q;
  assign row_o       = i_q;
  assign col_o       = j_q;
  assign last_tile_o = last_col_s & last_row_s;

endmodule

// File: rtl/mat_mul_tile_ctrl.sv
// mat_mul_tile_ctrl: sequences one mat_mul datapath over a T x T grid of tiles.
// For every output tile it clears the accumulator, issues T operand-tile reads,
// waits for T completions and offers the tile on a valid/ready handshake.
// Ports:
//   clk    : clock
//   resetn : synchronous reset, active HIGH (legacy name)
//   bus    : mat_mul_tile_ctrl_if.master - start/cfg_tiles/busy/done, rd_en and
//            a_addr/b_addr, mm_clr/mm_valid_in/mm_valid_out,
//            out_valid/out_ready/out_row/out_col, sticky err
// All outputs are registered.
module mat_mul_tile_ctrl
  import mat_mul_pkg::*;
#(
  parameter int N      = 2,
  parameter int MAX_T  = 8,
  parameter int MM_LAT = 2,
  parameter int AW     = 6,
  parameter int TW     = 4
) (
  input  logic               clk,
  input  logic               resetn,
  mat_mul_tile_ctrl_if.master bus
);

  localparam logic [2:0] S_IDLE   = ST_IDLE;
  localparam logic [2:0] S_CLEAR  = ST_CLEAR;
  localparam logic [2:0] S_ISSUE  = ST_ISSUE;
  localparam logic [2:0] S_DRAIN  = ST_DRAIN;
  localparam logic [2:0] S_OUTPUT = ST_OUTPUT;
  localparam logic [2:0] S_FIN    = ST_FIN;

  // In flight is bounded by the datapath depth plus the mm_valid_in stage.
  localparam int LAT_MAX = (MM_LAT > MM_LAT_OF(N)) ? MM_LAT : MM_LAT_OF(N);
  localparam int FW      = $clog2(LAT_MAX + 2) + 1;

  localparam logic [TW-1:0] MAX_T_V = TW'(MAX_T);
  localparam logic [TW-1:0] ZERO_T  = {TW{1'b0}};
  localparam logic [TW-1:0] ONE_T   = {{(TW-1){1'b0}}, 1'b1};
  localparam logic [FW-1:0] ZERO_F  = {FW{1'b0}};
  localparam logic [FW-1:0] ONE_F   = {{(FW-1){1'b0}}, 1'b1};
  localparam logic [FW-1:0] MAX_F   = {FW{1'b1}};

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] t_q, t_d;
  logic [TW-1:0] done_cnt_q, done_cnt_d;
  logic [FW-1:0] inflight_q, inflight_d;
  logic          err_q, err_d;
  logic          busy_q, done_q, rd_en_q, mm_clr_q, mvi_q, out_valid_q;

  logic [TW-1:0] cfg_clamped_s;
  logic [TW-1:0] done_cnt_nx_s;
  logic          spur_s;
  logic          init_s, load_s, step_s, adv_s;
  logic          last_k_s, last_tile_s;
  logic [AW-1:0] a_addr_s, b_addr_s;
  logic [TW-2:0] row_s, col_s;

  assign cfg_clamped_s = (bus.cfg_tiles > MAX_T_V) ? MAX_T_V : bus.cfg_tiles;
  assign spur_s        = bus.mm_valid_out && (inflight_q == ZERO_F);
  assign done_cnt_nx_s = (bus.mm_valid_out && (done_cnt_q != {TW{1'b1}}))
                         ? done_cnt_q + ONE_T : done_cnt_q;

  assign init_s = (state_q == S_IDLE) && bus.start;
  assign load_s = (state_q == S_CLEAR);
  assign step_s = (state_q == S_ISSUE);
  assign adv_s  = (state_q == S_OUTPUT) && bus.out_ready;

  mm_tile_addr_gen #(
    .AW (AW),
    .TW (TW)
  ) u_addr_gen (
    .clk         (clk),
    .resetn      (resetn),
    .tiles_i     (t_q),
    .init_i      (init_s),
    .load_i      (load_s),
    .step_i      (step_s),
    .adv_i       (adv_s),
    .a_addr_o    (a_addr_s),
    .b_addr_o    (b_addr_s),
    .row_o       (row_s),
    .col_o       (col_s),
    .last_k_o    (last_k_s),
    .last_tile_o (last_tile_s)
  );

  // Controller state transitions and tile-count latch.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          t_d = cfg_clamped_s;
          // A zero-tile command spends its single busy cycle in DRAIN, then FIN.
          state_d = (cfg_clamped_s == ZERO_T) ? S_DRAIN : S_CLEAR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: state_d = S_ISSUE;
      S_ISSUE: begin
        if (last_k_s) state_d = S_DRAIN;
        else          state_d = S_ISSUE;
      end
      S_DRAIN: begin
        // Look at the count including this cycle's completion to save a cycle.
        if (t_q == ZERO_T)              state_d = S_FIN;
        else if (done_cnt_nx_s == t_q)  state_d = S_OUTPUT;
        else                            state_d = S_DRAIN;
      end
      S_OUTPUT: begin
        if (bus.out_ready) state_d = last_tile_s ? S_FIN : S_CLEAR;
        else               state_d = S_OUTPUT;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // In-flight tracking, per-tile completion count and sticky error.
  always_comb begin
    inflight_d = inflight_q;
    case ({mvi_q, bus.mm_valid_out})
      2'b10: begin
        if (inflight_q != MAX_F) inflight_d = inflight_q + ONE_F;
        else                     inflight_d = inflight_q;
      end
      2'b01: begin
        if (inflight_q != ZERO_F) inflight_d = inflight_q - ONE_F;
        else                      inflight_d = ZERO_F;
      end
      default: inflight_d = inflight_q;
    endcase
    if (init_s || load_s) done_cnt_d = ZERO_T;
    else                  done_cnt_d = done_cnt_nx_s;
    err_d = err_q | spur_s;
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q     <= S_IDLE;
      t_q         <= ZERO_T;
      done_cnt_q  <= ZERO_T;
      inflight_q  <= ZERO_F;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      mm_clr_q    <= 1'b0;
      mvi_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      done_cnt_q  <= done_cnt_d;
      inflight_q  <= inflight_d;
      err_q       <= err_d;
      busy_q      <= (state_d != S_IDLE) && (state_d != S_FIN);
      done_q      <= (state_d == S_FIN);
      rd_en_q     <= (state_d == S_ISSUE);
      mm_clr_q    <= (state_d == S_CLEAR);
      mvi_q       <= rd_en_q;
      out_valid_q <= (state_d == S_OUTPUT);
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.rd_en       = rd_en_q;
  assign bus.a_addr      = a_addr_s;
  assign bus.b_addr      = b_addr_s;
  assign bus.mm_clr      = mm_clr_q;
  assign bus.mm_valid_in = mvi_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_row     = row_s;
  assign bus.out_col     = col_s;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_mat_mul_tile_ctrl.sv
// Testbench for mat_mul_tile_ctrl: datapath model with fixed latency, address
// and output-tile scoreboards, a table of commands and hand-written sequences.
module tb_mat_mul_tile_ctrl;

  localparam int MM_LAT = 2;
  localparam int AW     = 6;
  localparam int TW     = 4;
  localparam int MAX_T  = 8;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  mat_mul_tile_ctrl_if #(.AW(AW), .TW(TW)) bus ();

  mat_mul_tile_ctrl #(
    .N(2), .MAX_T(MAX_T), .MM_LAT(MM_LAT), .AW(AW), .TW(TW)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct { int a; int b; } rd_t;
  typedef struct { int r; int c; } tile_t;
  typedef struct {
    int cfg; int stall_tile; int stall_len;
    int exp_tiles; int exp_reads; int exp_done;
  } vec_t;

  rd_t   rd_q[$];
  tile_t tile_q[$];
  vec_t  vecs[6];

  int checks = 0;
  int errors = 0;
  int rel, first_clr, first_rd, first_mvi, first_ov, first_done;
  int reads_seen, tiles_seen, clr_seen, done_seen, ov_seen;
  int stall_tile = -1;
  int stall_left = 0;
  int busy_start_at = -1;
  logic [MM_LAT:0] pipe = '0;
  logic spur = 1'b0;
  logic prev_rd = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (rel cycle %0d)", name, act, exp, rel);
    end
  endtask

  // One clock: sample after the edge, advance the datapath model, monitor.
  task automatic step();
    logic rst_edge;
    rd_t   re;
    tile_t te;
    rst_edge = resetn;
    @(posedge clk);
    #1;
    rel++;
    pipe = {pipe[MM_LAT-1:0], bus.mm_valid_in};
    bus.mm_valid_out = pipe[MM_LAT] | spur;

    if (bus.out_valid && tiles_seen == stall_tile && stall_left > 0) begin
      bus.out_ready = 1'b0;
      stall_left--;
      chk("stall_rd_en", bus.rd_en, 0);
      chk("stall_mm_clr", bus.mm_clr, 0);
      if (tile_q.size() > 0) begin
        chk("stall_row", bus.out_row, tile_q[0].r);
        chk("stall_col", bus.out_col, tile_q[0].c);
      end else begin
        chk("stall_tile_expected", 0, 1);
      end
    end else begin
      bus.out_ready = 1'b1;
    end

    chk("mvi_align", bus.mm_valid_in, rst_edge ? 0 : int'(prev_rd));
    prev_rd = bus.rd_en;

    if (bus.mm_clr && first_clr < 0) first_clr = rel;
    if (bus.rd_en && first_rd < 0) first_rd = rel;
    if (bus.mm_valid_in && first_mvi < 0) first_mvi = rel;
    if (bus.out_valid && first_ov < 0) first_ov = rel;
    if (bus.done && first_done < 0) first_done = rel;
    if (bus.mm_clr) clr_seen++;
    if (bus.done) done_seen++;
    if (bus.out_valid) ov_seen++;
    if (bus.mm_clr && bus.out_valid) chk("clr_while_valid", 1, 0);

    if (bus.rd_en) begin
      reads_seen++;
      if (rd_q.size() == 0) begin
        chk("extra_read", 1, 0);
      end else begin
        re = rd_q.pop_front();
        chk("a_addr", bus.a_addr, re.a);
        chk("b_addr", bus.b_addr, re.b);
      end
    end

    if (bus.out_valid && bus.out_ready) begin
      tiles_seen++;
      if (tile_q.size() == 0) begin
        chk("extra_tile", 1, 0);
      end else begin
        te = tile_q.pop_front();
        chk("out_row", bus.out_row, te.r);
        chk("out_col", bus.out_col, te.c);
      end
    end
  endtask

  // Push expectations for a command and pulse start in cycle 0.
  task automatic start_cmd(input int cfg);
    int t;
    t = (cfg > MAX_T) ? MAX_T : cfg;
    rd_q.delete();
    tile_q.delete();
    for (int i = 0; i < t; i++)
      for (int j = 0; j < t; j++) begin
        tile_q.push_back('{r: i, c: j});
        for (int k = 0; k < t; k++) rd_q.push_back('{a: i * t + k, b: k * t + j});
      end
    first_clr = -1; first_rd = -1; first_mvi = -1; first_ov = -1; first_done = -1;
    reads_seen = 0; tiles_seen = 0; clr_seen = 0; done_seen = 0; ov_seen = 0;
    bus.cfg_tiles = TW'(cfg);
    bus.start = 1'b1;
    rel = 0;
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int c = 0; c < budget && done_seen == 0; c++) begin
      if (rel == busy_start_at) begin
        bus.cfg_tiles = 4'd3;
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      step();
    end
    bus.start = 1'b0;
    chk("done_seen", done_seen, 1);
    chk("busy_at_done", bus.busy, 0);
    step();
    chk("done_one_cycle", bus.done, 0);
    chk("reads_left", rd_q.size(), 0);
    chk("tiles_left", tile_q.size(), 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_rd_en"}, bus.rd_en, 0);
    chk({tag, "_mm_clr"}, bus.mm_clr, 0);
    chk({tag, "_mvi"}, bus.mm_valid_in, 0);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_err"}, bus.err, 0);
    chk({tag, "_a_addr"}, bus.a_addr, 0);
    chk({tag, "_b_addr"}, bus.b_addr, 0);
    chk({tag, "_out_row"}, bus.out_row, 0);
    chk({tag, "_out_col"}, bus.out_col, 0);
  endtask

  initial begin
    vecs[0] = '{cfg: 1,  stall_tile: -1, stall_len: 0,  exp_tiles: 1,  exp_reads: 1,   exp_done: 7};
    vecs[1] = '{cfg: 2,  stall_tile: -1, stall_len: 0,  exp_tiles: 4,  exp_reads: 8,   exp_done: 29};
    vecs[2] = '{cfg: 2,  stall_tile: 1,  stall_len: 10, exp_tiles: 4,  exp_reads: 8,   exp_done: 39};
    vecs[3] = '{cfg: 0,  stall_tile: -1, stall_len: 0,  exp_tiles: 0,  exp_reads: 0,   exp_done: 2};
    vecs[4] = '{cfg: 3,  stall_tile: -1, stall_len: 0,  exp_tiles: 9,  exp_reads: 27,  exp_done: 73};
    vecs[5] = '{cfg: 12, stall_tile: -1, stall_len: 0,  exp_tiles: 64, exp_reads: 512, exp_done: 833};

    bus.start = 1'b0;
    bus.cfg_tiles = 4'd0;
    bus.mm_valid_out = 1'b0;
    bus.out_ready = 1'b1;
    rel = 0;
    first_clr = -1; first_rd = -1; first_mvi = -1; first_ov = -1; first_done = -1;
    reads_seen = 0; tiles_seen = 0; clr_seen = 0; done_seen = 0; ov_seen = 0;

    // Power-on reset.
    resetn = 1'b1;
    step();
    step();
    check_zero("reset");
    resetn = 1'b0;
    step();

    // T=1 cycle-exact timing.
    start_cmd(1);
    wait_done(200);
    chk("t1_clr_cycle", first_clr, 1);
    chk("t1_rd_cycle", first_rd, 2);
    chk("t1_mvi_cycle", first_mvi, 3);
    chk("t1_ov_cycle", first_ov, 6);
    chk("t1_done_cycle", first_done, 7);

    // Table of commands.
    for (int v = 0; v < 6; v++) begin
      stall_tile = vecs[v].stall_tile;
      stall_left = vecs[v].stall_len;
      start_cmd(vecs[v].cfg);
      wait_done(3000);
      chk("vec_tiles", tiles_seen, vecs[v].exp_tiles);
      chk("vec_reads", reads_seen, vecs[v].exp_reads);
      chk("vec_clears", clr_seen, vecs[v].exp_tiles);
      chk("vec_ov_cycles", ov_seen, vecs[v].exp_tiles + vecs[v].stall_len);
      chk("vec_done_cycle", first_done, vecs[v].exp_done);
      chk("vec_err", bus.err, 0);
      stall_tile = -1;
      stall_left = 0;
    end

    // Reset in the middle of ISSUE of a T=4 command.
    start_cmd(4);
    step();
    step();
    chk("pre_reset_rd_en", bus.rd_en, 1);
    resetn = 1'b1;
    step();
    check_zero("midreset");
    resetn = 1'b0;
    pipe = '0;
    bus.mm_valid_out = 1'b0;
    rd_q.delete();
    tile_q.delete();
    step();
    start_cmd(1);
    wait_done(200);
    chk("post_reset_tiles", tiles_seen, 1);
    chk("post_reset_err", bus.err, 0);
    chk("post_reset_done_cycle", first_done, 7);

    // Spurious completion in IDLE, then a T=1 run with a start pulse while busy.
    spur = 1'b1;
    step();
    spur = 1'b0;
    step();
    chk("spur_err_set", bus.err, 1);
    busy_start_at = 3;
    start_cmd(1);
    wait_done(200);
    busy_start_at = -1;
    chk("spur_tiles", tiles_seen, 1);
    chk("spur_reads", reads_seen, 1);
    chk("spur_done_cycle", first_done, 7);
    chk("spur_err_sticky", bus.err, 1);
    step();
    step();
    chk("spur_idle_busy", bus.busy, 0);
    chk("spur_no_extra_read", reads_seen, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mat_mul_tile_ctrl.md
Name: mat_mul_tile_ctrl

Overview:
- Sequences one mat_mul datapath (N×N tile multiplier with output accumulator) to compute a tiled product C = A×B of (T·N)×(T·N) matrices.
- A and B are held in external tile buffers. Each buffer word is one N×N tile, with a 1-cycle read latency.
- For every output tile (i,j) the block clears the accumulator, issues the T operand-tile pairs (i,k),(k,j) and counts completions. It then presents the accumulated tile on a valid/ready output handshake.
- Sits between the tile buffers / host command interface and the mat_mul datapath.

Parameters:
- N, 2, tile dimension of the datapath; power of two, ≥2.
- MAX_T, 8, maximum tiles per matrix side.
- MM_LAT, 2, datapath latency in cycles from mm_valid_in to mm_valid_out; equals clog2(N)+1.
- AW, 6, tile-buffer address width; equals clog2(MAX_T·MAX_T).
- TW, 4, tile-count width; equals clog2(MAX_T)+1.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-high reset (name retained from codebase).
- start  in  1  command strobe; sampled only in IDLE.
- cfg_tiles  in  TW  tiles per side T, latched on accepted start.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the last output tile is accepted.
- rd_en  out  1  tile-buffer read enable, common to A and B.
- a_addr  out  AW  A tile address, = i·T+k.
- b_addr  out  AW  B tile address, = k·T+j.
- mm_clr  out  1  one-cycle accumulator clear to the datapath.
- mm_valid_in  out  1  rd_en delayed 1 cycle (aligned with buffer data).
- mm_valid_out  in  1  datapath completion pulse; the accumulator already includes that contribution.
- out_valid  out  1  accumulated tile available on the datapath result bus.
- out_ready  in  1  consumer accepts the tile.
- out_row  out  TW-1  output tile row index i.
- out_col  out  TW-1  output tile column index j.
- err  out  1  sticky: mm_valid_out received with nothing in flight.

Behaviour:
- Reset (resetn=1 at an edge), from any state including mid-operation:
  - state=IDLE.
  - busy, done, rd_en, mm_clr, mm_valid_in, out_valid and err are all 0.
  - a_addr, b_addr, out_row, out_col and all counters are 0.
  - No further reads are issued and in-flight results are discarded.
- States: IDLE, CLEAR, ISSUE, DRAIN, OUTPUT, FIN.
- IDLE:
  - start=1 latches T=cfg_tiles, sets i=j=0 and busy=1.
  - If T=0, go to FIN (no reads, no output). Otherwise go to CLEAR.
  - start while busy is ignored.
- CLEAR: mm_clr=1 for exactly one cycle, with no issue in the same cycle; set k=0; go to ISSUE.
- ISSUE:
  - rd_en=1 for T consecutive cycles, one per k=0..T-1, with addresses as above.
  - After the k=T-1 cycle, go to DRAIN.
- Issue/completion pipeline:
  - mm_valid_in is rd_en registered once.
  - An in-flight counter increments on each mm_valid_in and decrements on each mm_valid_out; simultaneous events leave it unchanged.
  - The done_cnt for the current tile increments on each mm_valid_out.
- DRAIN: wait until done_cnt==T; then go to OUTPUT. Minimum cycles from CLEAR to OUTPUT = 1+T+1+MM_LAT.
- OUTPUT:
  - out_valid=1 with out_row=i and out_col=j, held stable until out_ready.
  - On out_valid&out_ready:
    - if j<T-1, increment j and go to CLEAR;
    - else if i<T-1, set j=0, increment i and go to CLEAR;
    - else go to FIN.
  - out_ready is ignored outside OUTPUT.
  - mm_clr is never asserted while out_valid=1, so the tile is not corrupted under backpressure.
- FIN: done=1 for one cycle, busy=0, go to IDLE. A start in that same cycle is ignored.
- Error: mm_valid_out while the in-flight count is 0 sets err. err clears only on reset. The counters saturate at 0 (no underflow).
- cfg_tiles > MAX_T: clamp to MAX_T.
- Address arithmetic:
  - Unsigned.
  - Implemented with incremental counters; no runtime multiplier.

Decomposition:
- Package mat_mul_pkg:
  - state enum mm_ctrl_state_t;
  - localparams MM_LAT_OF(N) = clog2(N)+1;
  - AW/TW derivation functions.
- Sub-module mm_tile_addr_gen: holds the i/j/k counters and row-base pointers, generating a_addr/b_addr and the last-k / last-tile flags.
- FSM, in-flight counter and error logic stay in the top.

Test Plan:
- T=1, out_ready=1, MM_LAT=2:
  - start → mm_clr at cycle 1, rd_en at cycle 2 with a_addr=b_addr=0, mm_valid_in at cycle 3;
  - bench returns mm_valid_out at cycle 5 → out_valid at cycle 6 with (0,0);
  - done at cycle 7.
- T=2:
  - rd_en sequence gives a_addr,b_addr = (0,0),(1,2) for tile (0,0); (0,1),(1,3) for (0,1); (2,0),(3,2) for (1,0); (2,1),(3,3) for (1,1);
  - 4 output tiles in row-major order, then a single done.
- T=2, out_ready held 0 for 10 cycles on tile (0,1):
  - out_valid, out_row=0 and out_col=1 stay stable;
  - no mm_clr and no rd_en during the stall;
  - resumes correctly after the stall.
- cfg_tiles=0: done pulses 2 cycles after start; rd_en, mm_clr and out_valid are never asserted.
- resetn=1 asserted during ISSUE of T=4: all outputs 0 next cycle; a new start with T=1 then completes normally with err=0.
- Spurious mm_valid_out pulse in IDLE: err=1 and stays 1 through a following T=1 run, which still completes; the start pulse issued while busy has no effect.
